registrador_de_estado_param: RTL
================================

Name: registrador_de_estado_param

Overview:
- Parametrised, WIDTH-bit state register for the ALU sequencers.
- Generalises the fixed 2-bit state register in four ways: configurable width, configurable legal-state count and reset state, a load/step/hold command interface, and illegal-state recovery.
- Adds observability outputs: previous state, a change pulse, and a saturating dwell counter.
- Sits between a sequencer's next-state logic and its output decoding.

Parameters:
- WIDTH, 2: state bit width.
- NUM_STATES, 4: number of legal states, 0..NUM_STATES-1. Must satisfy 2 <= NUM_STATES <= 2**WIDTH.
- RESET_STATE, 0: state after reset and after illegal-load recovery. Must be < NUM_STATES.
- CNT_W, 8: width of the dwell counter.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- en  input  1  command enable; when 0, the state holds.
- carregar  input  1  load proximo_estado (valid only when en=1).
- avancar  input  1  step to the next sequential state (valid only when en=1).
- proximo_estado  input  WIDTH  state value to load.
- estado_atual  output  WIDTH  registered current state.
- estado_anterior  output  WIDTH  state held before the most recent actual change.
- mudou  output  1  one-cycle pulse marking the first cycle of a new state.
- erro_estado  output  1  sticky illegal-load flag.
- ciclos_no_estado  output  CNT_W  completed cycles spent in the current state, saturating.

Behaviour:
- All outputs are registered. No combinational path from inputs to outputs.
- Reset (reset_n=0 at a rising edge) sets:
  - estado_atual=RESET_STATE, estado_anterior=RESET_STATE
  - mudou=0, erro_estado=0, ciclos_no_estado=0
- Reset overrides every other input in the same cycle, including mid-sequence. No synchronous-reset-only state survives.
- Next-state selection, in priority order:
  - en=0: hold. carregar and avancar are ignored.
  - en=1, carregar=1: load path. carregar wins over avancar when both are asserted.
    - proximo_estado < NUM_STATES: next = proximo_estado.
    - proximo_estado >= NUM_STATES: next = RESET_STATE, and erro_estado is set to 1.
  - en=1, carregar=0, avancar=1: next = estado_atual+1. Wrap-around: from NUM_STATES-1 the next state is 0.
  - en=1, neither command: hold.
- Latency: one cycle. A command sampled at edge N is visible on estado_atual after edge N.
- Actual change means next != estado_atual. On an actual change, at the same edge:
  - estado_anterior <= old estado_atual
  - mudou <= 1
  - ciclos_no_estado <= 0
- No actual change (hold, or a load of the current value):
  - estado_anterior holds
  - mudou <= 0
  - ciclos_no_estado increments by 1, saturating at 2**CNT_W-1
- Illegal load while estado_atual==RESET_STATE:
  - erro_estado is set.
  - No actual change occurs, so mudou=0 and the counter keeps counting.
- erro_estado is sticky. Only reset clears it. Later legal commands do not clear it.
- estado_atual never holds a value >= NUM_STATES outside reset.
- With NUM_STATES == 2**WIDTH, illegal loads are unreachable; wrap-around falls out of natural overflow.
- Elaboration must fail (generate-time check) if:
  - NUM_STATES > 2**WIDTH, or
  - RESET_STATE >= NUM_STATES.

Test Plan:
(Configuration unless noted: WIDTH=2, NUM_STATES=3, RESET_STATE=0, CNT_W=4.)
- Reset then idle: hold reset_n=0 for 2 cycles, then release with en=0 for 20 cycles.
  -> estado_atual=0, estado_anterior=0, mudou=0, erro_estado=0.
  -> ciclos_no_estado counts 1..15, then stays at 15.
- Step with wrap-around: en=1, avancar=1 for 4 cycles.
  -> estado_atual sequence 1,2,0,1.
  -> mudou=1 in each of those cycles.
  -> estado_anterior sequence 0,1,2,0.
  -> ciclos_no_estado=0 in each.
- Load priority: en=1, carregar=1, avancar=1, proximo_estado=2, starting from state 0.
  -> estado_atual=2 (not 1), mudou=1.
  -> Next cycle, load 2 again: mudou=0, ciclos_no_estado=1.
- Illegal load: from state 2, carregar=1 with proximo_estado=3.
  -> estado_atual=0, estado_anterior=2, mudou=1, erro_estado=1.
  -> Then legal steps: erro_estado stays 1 until reset_n=0.
- Enable gating: en=0 with carregar=1 and proximo_estado=1 for 3 cycles.
  -> State unchanged, mudou=0, counter increments by 3.
- Mid-operation reset: assert reset_n=0 in the same cycle as a legal load of 2 from state 1.
  -> Next cycle estado_atual=0, estado_anterior=0, mudou=0, erro_estado=0, ciclos_no_estado=0.
  -> Repeat with WIDTH=3, NUM_STATES=8, RESET_STATE=5: stepping from 7 gives 0, and reset gives 5.

Source files
------------

// File: rtl/registrador_de_estado_param.sv
// ============================================================================
// registrador_de_estado_param : parametrised sequencer state register with
// load/step/hold commands, illegal-load recovery and dwell observability.
// Rev 1.0
// ============================================================================
`default_nettype none

module registrador_de_estado_param #(
  parameter int WIDTH       = 2,
  parameter int NUM_STATES  = 4,
  parameter int RESET_STATE = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             carregar,
  input  logic             avancar,
  input  logic [WIDTH-1:0] proximo_estado,
  output logic [WIDTH-1:0] estado_atual,
  output logic [WIDTH-1:0] estado_anterior,
  output logic             mudou,
  output logic             erro_estado,
  output logic [CNT_W-1:0] ciclos_no_estado
);

  localparam logic [WIDTH-1:0] c_reset = WIDTH'(RESET_STATE);
  localparam logic [WIDTH-1:0] c_last  = WIDTH'(NUM_STATES - 1);

  generate
    if ((NUM_STATES > (2 ** WIDTH)) || (RESET_STATE >= NUM_STATES) ||
        (NUM_STATES < 2) || (RESET_STATE < 0)) begin : g_bad_params
      $error("registrador_de_estado_param: illegal NUM_STATES/RESET_STATE");
    end
  endgenerate

  logic load_legal;

  // When every encoding is a legal state the range check is constant-true.
  generate
    if (NUM_STATES == (2 ** WIDTH)) begin : g_full_range
      assign load_legal = 1'b1;
    end else begin : g_partial_range
      assign load_legal = (proximo_estado <= c_last);
    end
  endgenerate

  logic [WIDTH-1:0] estado_q,   estado_d;
  logic [WIDTH-1:0] anterior_q, anterior_d;
  logic             mudou_q,    mudou_d;
  logic             erro_q,     erro_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;
  logic             changed;

  always_comb begin
    estado_d = estado_q;
    erro_d   = erro_q;
    if (en) begin
      if (carregar) begin
        if (load_legal) begin
          estado_d = proximo_estado;
        end else begin
          estado_d = c_reset;
          erro_d   = 1'b1;
        end
      end else if (avancar) begin
        estado_d = (estado_q == c_last) ? '0 : estado_q + WIDTH'(1);
      end
    end

    changed    = (estado_d != estado_q);
    anterior_d = changed ? estado_q : anterior_q;
    mudou_d    = changed;
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado_q   <= c_reset;
      anterior_q <= c_reset;
      mudou_q    <= 1'b0;
      erro_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      anterior_q <= anterior_d;
      mudou_q    <= mudou_d;
      erro_q     <= erro_d;
      cnt_q      <= cnt_d;
    end
  end

  assign estado_atual     = estado_q;
  assign estado_anterior  = anterior_q;
  assign mudou            = mudou_q;
  assign erro_estado      = erro_q;
  assign ciclos_no_estado = cnt_q;

endmodule

`default_nettype wire
